// File: rtl/bp_table_scheduler_pkg.sv
// Shared types and helpers for the branch-history table scheduler.
package bp_table_scheduler_pkg;

    // Index width the update-entry struct is built with; the top defaults to it.
    localparam int BP_TABLE_WIDTH = 6;

    // Every counter starts at weakly-taken after reset.
    localparam logic [1:0] WEAK_TAKEN = 2'b10;

    typedef enum logic [1:0] {
        INIT      = 2'd0,
        IDLE      = 2'd1,
        UPD_WRITE = 2'd2
    } schedState_t;

    // One queued ROB commit: table index plus the resolved direction.
    typedef struct packed {
        logic [BP_TABLE_WIDTH-1:0] idx;
        logic                      taken;
    } updEntry_t;

    // 2-bit saturating counter step.
    function automatic logic [1:0] counterNext(input logic [1:0] cur, input logic taken);
        if (taken) return (cur == 2'b11) ? cur : cur + 2'd1;
        return (cur == 2'b00) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table_scheduler_if.sv
// Lookup, commit-update and table RAM signals of the scheduler.
interface bp_table_scheduler_if #(parameter int TABLE_WIDTH = 6);
    logic                   predictValid;
    logic [31:0]            predictAddr;
    logic                   predictReady;
    logic                   jumpValid;
    logic                   jump;
    logic                   updateFlag;
    logic [31:0]            updateAddr;
    logic                   updateVal;
    logic                   tableEn;
    logic                   tableWe;
    logic [TABLE_WIDTH-1:0] tableAddr;
    logic [1:0]             tableWdata;
    logic [1:0]             tableRdata;

    // Requester side: instruction unit, ROB and the table RAM read port.
    modport master (
        output predictValid, predictAddr, updateFlag, updateAddr, updateVal, tableRdata,
        input  predictReady, jumpValid, jump, tableEn, tableWe, tableAddr, tableWdata
    );

    // Scheduler side.
    modport slave (
        input  predictValid, predictAddr, updateFlag, updateAddr, updateVal, tableRdata,
        output predictReady, jumpValid, jump, tableEn, tableWe, tableAddr, tableWdata
    );
endinterface

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO holding committed branch updates; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module bp_update_fifo #(
    parameter int DATA_W  = 7,
    parameter int DEPTH_W = 2
) (
    input  logic              clockIn,
    input  logic              resetIn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] pushData,
    output logic [DATA_W-1:0] headData,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << DEPTH_W;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH_W:0]   wrPtr;
    logic [DEPTH_W:0]   rdPtr;
    logic               pushOk;
    logic               popOk;

    // Extra pointer bit separates full from empty when the slot bits match.
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[DEPTH_W] != rdPtr[DEPTH_W]) &&
                      (wrPtr[DEPTH_W-1:0] == rdPtr[DEPTH_W-1:0]);
    assign pushOk   = push && (!full || pop);
    assign popOk    = pop && !empty;
    assign headData = mem[rdPtr[DEPTH_W-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popOk)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clockIn) begin
        if (resetIn && pushOk) mem[wrPtr[DEPTH_W-1:0]] <= pushData;
    end

endmodule

// File: rtl/bp_table_scheduler.sv
// Owns the single-port 2-bit branch history table: initialises it, serves
// lookups, and applies queued commit updates as read-modify-write pairs.
module bp_table_scheduler
    import bp_table_scheduler_pkg::*;
#(
    // The update-entry struct is sized by BP_TABLE_WIDTH; keep these equal.
    parameter int TABLE_WIDTH  = BP_TABLE_WIDTH,
    parameter int QUEUE_WIDTH  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clockIn,
    input  logic                resetIn,
    input  logic                readyIn,
    bp_table_scheduler_if.slave bus,
    output logic                initDone,
    output logic [15:0]         dropCount
);
    localparam int                 STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    schedState_t            state;
    logic [TABLE_WIDTH-1:0] initIdx;
    logic [STARVE_W-1:0]    starve;
    logic                   jumpValidQ;
    updEntry_t              pushEntry;
    updEntry_t              head;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   fifoPush;
    logic                   fifoPop;
    logic                   dropUpd;
    logic                   active;
    logic                   updPrio;
    logic                   lookupFire;
    logic [TABLE_WIDTH-1:0] lookIdx;
    logic                   unusedAddrBits;

    // Reset overrides everything, so nothing reaches the RAM while it is low.
    assign active     = readyIn && resetIn;
    assign lookIdx    = bus.predictAddr[TABLE_WIDTH+1:2];
    assign pushEntry  = '{idx: bus.updateAddr[TABLE_WIDTH+1:2], taken: bus.updateVal};

    // Updates take the port when lookups are absent, the queue is full, or
    // the queue has lost too many arbitrations in a row.
    assign updPrio    = !fifoEmpty &&
                        (!bus.predictValid || fifoFull || starve >= STARVE_MAX);
    assign lookupFire = active && (state == IDLE) && !updPrio && bus.predictValid;
    assign fifoPop    = active && (state == UPD_WRITE);
    assign fifoPush   = active && bus.updateFlag;
    assign dropUpd    = fifoPush && fifoFull && !fifoPop;

    assign bus.jumpValid = jumpValidQ;
    assign bus.jump      = bus.tableRdata[1];

    assign unusedAddrBits = ^{bus.predictAddr[31:TABLE_WIDTH+2], bus.predictAddr[1:0],
                              bus.updateAddr[31:TABLE_WIDTH+2], bus.updateAddr[1:0]};

    bp_update_fifo #(
        .DATA_W  ($bits(updEntry_t)),
        .DEPTH_W (QUEUE_WIDTH)
    ) updFifo (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .push     (fifoPush),
        .pop      (fifoPop),
        .pushData (pushEntry),
        .headData (head),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // RAM port and lookup handshake, decoded from the current state.
    always_comb begin
        bus.tableEn      = 1'b0;
        bus.tableWe      = 1'b0;
        bus.tableAddr    = '0;
        bus.tableWdata   = '0;
        bus.predictReady = 1'b0;
        if (active) begin
            case (state)
                INIT: begin
                    bus.tableEn    = 1'b1;
                    bus.tableWe    = 1'b1;
                    bus.tableAddr  = initIdx;
                    bus.tableWdata = WEAK_TAKEN;
                end
                IDLE: begin
                    if (updPrio) begin
                        bus.tableEn   = 1'b1;
                        bus.tableAddr = head.idx;
                    end else begin
                        bus.predictReady = 1'b1;
                        if (bus.predictValid) begin
                            bus.tableEn   = 1'b1;
                            bus.tableAddr = lookIdx;
                        end
                    end
                end
                UPD_WRITE: begin
                    // Head is still the entry read last cycle; pop happens now.
                    bus.tableEn    = 1'b1;
                    bus.tableWe    = 1'b1;
                    bus.tableAddr  = head.idx;
                    bus.tableWdata = counterNext(bus.tableRdata, head.taken);
                end
                default: ;
            endcase
        end
    end

    // Scheduler FSM, starvation counter, drop counter and lookup valid.
    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            state      <= INIT;
            initIdx    <= '0;
            starve     <= '0;
            jumpValidQ <= 1'b0;
            initDone   <= 1'b0;
            dropCount  <= '0;
        end else if (readyIn) begin
            jumpValidQ <= lookupFire;
            if (dropUpd && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
            case (state)
                INIT: begin
                    initIdx <= initIdx + 1'b1;
                    if (initIdx == '1) begin
                        state    <= IDLE;
                        initDone <= 1'b1;
                    end
                end
                IDLE: begin
                    if (updPrio) begin
                        starve <= '0;
                        state  <= UPD_WRITE;
                    end else if (bus.predictValid && !fifoEmpty && starve < STARVE_MAX) begin
                        starve <= starve + 1'b1;
                    end
                end
                UPD_WRITE: state <= IDLE;
                default:   state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Scoreboard bench for bp_table_scheduler with a behavioural 1-cycle table RAM.
module tb_bp_table_scheduler;

    typedef struct {
        logic [5:0] addr;
        logic [1:0] data;
    } wr_t;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        readyIn = 1'b0;
    logic        initDone;
    logic [15:0] dropCount;

    int checks   = 0;
    int failures = 0;

    wr_t  expWr[$];
    logic expBit[$];
    logic expJv[$];

    logic [1:0] ram [0:63];

    bp_table_scheduler_if #(.TABLE_WIDTH(6)) bus ();

    bp_table_scheduler #(.TABLE_WIDTH(6), .QUEUE_WIDTH(2), .STARVE_LIMIT(8)) dut (
        .clockIn   (clockIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .bus       (bus),
        .initDone  (initDone),
        .dropCount (dropCount)
    );

    always #5 clockIn = ~clockIn;

    // Table RAM: one-cycle read latency, output holds when not reading.
    always @(posedge clockIn) begin
        if (bus.tableEn) begin
            if (bus.tableWe) ram[bus.tableAddr] <= bus.tableWdata;
            else             bus.tableRdata <= ram[bus.tableAddr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            resetIn = 1'b0;
            readyIn = 1'b1;
            bus.predictValid = 1'b1;
            @(negedge clockIn);
            checks++;
            if (bus.jumpValid !== 1'b0 || initDone !== 1'b0 || dropCount !== 16'd0) begin
                failures++;
                $display("FAIL reset_regs jv=%b initDone=%b drop=%0d want 0/0/0",
                         bus.jumpValid, initDone, dropCount);
            end
            checks++;
            if (bus.tableEn !== 1'b0 || bus.predictReady !== 1'b0) begin
                failures++;
                $display("FAIL reset_port en=%b ready=%b want 0/0", bus.tableEn, bus.predictReady);
            end
        end
    endtask

    task automatic test_init();
        wr_t w;
        for (int i = 0; i < 64; i++) expWr.push_back('{6'(i), 2'b10});
        for (int i = 0; i < 64; i++) begin
            step();
            resetIn = 1'b1;
            bus.predictValid = 1'b1;
            bus.predictAddr = 32'h0;
            @(negedge clockIn);
            checks++;
            if (bus.tableEn !== 1'b1 || bus.tableWe !== 1'b1 || expWr.size() == 0) begin
                failures++;
                $display("FAIL init_write cycle=%0d en=%b we=%b want en=1 we=1", i, bus.tableEn, bus.tableWe);
            end else begin
                w = expWr.pop_front();
                if (bus.tableAddr !== w.addr || bus.tableWdata !== w.data) begin
                    failures++;
                    $display("FAIL init_write cycle=%0d addr=%0d data=%b want addr=%0d data=%b",
                             i, bus.tableAddr, bus.tableWdata, w.addr, w.data);
                end
            end
            checks++;
            if (bus.predictReady !== 1'b0 || initDone !== 1'b0) begin
                failures++;
                $display("FAIL init_hold cycle=%0d ready=%b initDone=%b want 0/0", i, bus.predictReady, initDone);
            end
        end
        step();
        bus.predictValid = 1'b0;
        @(negedge clockIn);
        checks++;
        if (initDone !== 1'b1 || bus.predictReady !== 1'b1) begin
            failures++;
            $display("FAIL init_done initDone=%b ready=%b want 1/1", initDone, bus.predictReady);
        end
        expWr.delete();
    endtask

    task automatic test_lookup();
        logic e;
        step();
        bus.predictValid = 1'b1;
        bus.predictAddr  = 32'h104;
        expBit.push_back(1'b1);
        @(negedge clockIn);
        checks++;
        if (bus.predictReady !== 1'b1 || bus.tableEn !== 1'b1 || bus.tableWe !== 1'b0 || bus.tableAddr !== 6'h01) begin
            failures++;
            $display("FAIL lookup_issue ready=%b en=%b we=%b addr=%0h want 1/1/0/01",
                     bus.predictReady, bus.tableEn, bus.tableWe, bus.tableAddr);
        end
        step();
        bus.predictValid = 1'b0;
        @(negedge clockIn);
        e = expBit.pop_front();
        checks++;
        if (bus.jumpValid !== 1'b1 || bus.jump !== e) begin
            failures++;
            $display("FAIL lookup_result jv=%b jump=%b want 1/%b", bus.jumpValid, bus.jump, e);
        end
        step();
        @(negedge clockIn);
        checks++;
        if (bus.jumpValid !== 1'b0) begin
            failures++;
            $display("FAIL lookup_jv_drop jv=%b want 0", bus.jumpValid);
        end
    endtask

    task automatic test_update_rmw();
        logic       vals [5];
        logic [1:0] exps [5];
        wr_t        w;
        int         seen;
        bit         jvBad;
        logic       e;
        vals = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exps = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        seen = 0;
        jvBad = 0;
        for (int c = 0; c < 30 && (c < 5 || expWr.size() != 0); c++) begin
            step();
            bus.predictValid = 1'b0;
            if (c < 5) begin
                bus.updateFlag = 1'b1;
                bus.updateAddr = 32'h104;
                bus.updateVal  = vals[c];
                expWr.push_back('{6'h01, exps[c]});
            end else begin
                bus.updateFlag = 1'b0;
            end
            @(negedge clockIn);
            if (bus.jumpValid !== 1'b0) jvBad = 1;
            if (bus.tableEn === 1'b1 && bus.tableWe === 1'b1) begin
                checks++;
                seen++;
                if (expWr.size() == 0) begin
                    failures++;
                    $display("FAIL rmw_write unexpected addr=%0d data=%b", bus.tableAddr, bus.tableWdata);
                end else begin
                    w = expWr.pop_front();
                    if (bus.tableAddr !== w.addr || bus.tableWdata !== w.data) begin
                        failures++;
                        $display("FAIL rmw_write #%0d addr=%0d data=%b want addr=%0d data=%b",
                                 seen, bus.tableAddr, bus.tableWdata, w.addr, w.data);
                    end
                end
            end
        end
        bus.updateFlag = 1'b0;
        checks++;
        if (seen != 5 || expWr.size() != 0) begin
            failures++;
            $display("FAIL rmw_count writes=%0d pending=%0d want 5/0", seen, expWr.size());
        end
        expWr.delete();
        checks++;
        if (jvBad) begin
            failures++;
            $display("FAIL rmw_jv jumpValid=1 want 0 with no lookups");
        end
        step();
        bus.predictValid = 1'b1;
        bus.predictAddr  = 32'h104;
        expBit.push_back(1'b0);
        step();
        bus.predictValid = 1'b0;
        @(negedge clockIn);
        e = expBit.pop_front();
        checks++;
        if (bus.jumpValid !== 1'b1 || bus.jump !== e) begin
            failures++;
            $display("FAIL rmw_lookup jv=%b jump=%b want 1/%b", bus.jumpValid, bus.jump, e);
        end
    endtask

    task automatic test_starve();
        logic er;
        logic ej;
        wr_t  w;
        step();
        bus.predictValid = 1'b0;
        bus.updateFlag   = 1'b1;
        bus.updateAddr   = 32'h208;
        bus.updateVal    = 1'b1;
        expWr.push_back('{6'd2, 2'b11});
        for (int c = 1; c <= 11; c++) begin
            step();
            bus.updateFlag   = 1'b0;
            bus.predictValid = 1'b1;
            bus.predictAddr  = 32'h10;
            expBit.push_back((c <= 8) || (c == 11));
            expJv.push_back((c >= 2) && (c <= 9));
            @(negedge clockIn);
            er = expBit.pop_front();
            ej = expJv.pop_front();
            checks++;
            if (bus.predictReady !== er) begin
                failures++;
                $display("FAIL starve_ready cycle=%0d got=%b want=%b", c, bus.predictReady, er);
            end
            checks++;
            if (bus.jumpValid !== ej || (ej && bus.jump !== 1'b1)) begin
                failures++;
                $display("FAIL starve_jv cycle=%0d jv=%b jump=%b want jv=%b jump=1", c, bus.jumpValid, bus.jump, ej);
            end
            if (bus.tableEn === 1'b1 && bus.tableWe === 1'b1) begin
                checks++;
                if (expWr.size() == 0 || c != 10) begin
                    failures++;
                    $display("FAIL starve_write cycle=%0d addr=%0d want single write at cycle 10", c, bus.tableAddr);
                end else begin
                    w = expWr.pop_front();
                    if (bus.tableAddr !== w.addr || bus.tableWdata !== w.data) begin
                        failures++;
                        $display("FAIL starve_write addr=%0d data=%b want addr=%0d data=%b",
                                 bus.tableAddr, bus.tableWdata, w.addr, w.data);
                    end
                end
            end
        end
        checks++;
        if (expWr.size() != 0) begin
            failures++;
            $display("FAIL starve_pending got=%0d want=0", expWr.size());
        end
        expWr.delete();
        step();
        bus.predictValid = 1'b0;
        @(negedge clockIn);
    endtask

    task automatic test_back_to_back();
        wr_t w;
        int  c;
        c = 0;
        while (c < 40 && (c < 6 || expWr.size() != 0)) begin
            step();
            bus.predictValid = 1'b1;
            bus.predictAddr  = 32'h10;
            if (c < 6) begin
                bus.updateFlag = 1'b1;
                bus.updateAddr = 32'((8 + c) << 2);
                bus.updateVal  = 1'b1;
                // Entry 4 arrives while full with no pop in that cycle.
                if (c != 4) expWr.push_back('{6'(8 + c), 2'b11});
            end else begin
                bus.updateFlag = 1'b0;
            end
            @(negedge clockIn);
            if (c == 4) begin
                checks++;
                if (bus.predictReady !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_full_prio ready=%b want 0", bus.predictReady);
                end
            end
            if (c == 5) begin
                checks++;
                if (dropCount !== 16'd1) begin
                    failures++;
                    $display("FAIL b2b_drop_early got=%0d want=1", dropCount);
                end
            end
            if (bus.jumpValid === 1'b1) begin
                checks++;
                if (bus.jump !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_jump got=%b want=1", bus.jump);
                end
            end
            if (bus.tableEn === 1'b1 && bus.tableWe === 1'b1) begin
                checks++;
                if (expWr.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_write unexpected addr=%0d", bus.tableAddr);
                end else begin
                    w = expWr.pop_front();
                    if (bus.tableAddr !== w.addr || bus.tableWdata !== w.data) begin
                        failures++;
                        $display("FAIL b2b_write addr=%0d data=%b want addr=%0d data=%b",
                                 bus.tableAddr, bus.tableWdata, w.addr, w.data);
                    end
                end
            end
            c++;
        end
        checks++;
        if (expWr.size() != 0 || dropCount !== 16'd1) begin
            failures++;
            $display("FAIL b2b_end pending=%0d drop=%0d want 0/1", expWr.size(), dropCount);
        end
        expWr.delete();
        step();
        bus.predictValid = 1'b0;
        bus.updateFlag   = 1'b0;
        @(negedge clockIn);
    endtask

    task automatic test_reset_in_rmw();
        wr_t w;
        int  initCnt;
        int  guard;
        initCnt = 0;
        step();
        bus.predictValid = 1'b0;
        bus.updateFlag   = 1'b1;
        bus.updateAddr   = 32'h14;
        bus.updateVal    = 1'b1;
        step();
        bus.updateFlag = 1'b0;
        @(negedge clockIn);
        checks++;
        if (bus.tableEn !== 1'b1 || bus.tableWe !== 1'b0 || bus.tableAddr !== 6'd5) begin
            failures++;
            $display("FAIL rst_upd_read en=%b we=%b addr=%0d want 1/0/5", bus.tableEn, bus.tableWe, bus.tableAddr);
        end
        step();
        resetIn = 1'b0;
        @(negedge clockIn);
        checks++;
        if (bus.tableEn !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_write en=%b want 0", bus.tableEn);
        end
        // Re-init with readyIn pulsed; updates land in a queue nothing drains.
        for (int k = 0; k < 14; k++) begin
            step();
            resetIn = 1'b1;
            readyIn = (k % 2 == 0);
            bus.updateFlag = 1'b1;
            bus.updateVal  = 1'b1;
            bus.updateAddr = readyIn ? 32'((20 + k / 2) << 2) : 32'(40 << 2);
            if (readyIn && (k / 2) < 4) expWr.push_back('{6'(20 + k / 2), 2'b11});
            @(negedge clockIn);
            if (k == 0) begin
                checks++;
                if (dropCount !== 16'd0 || initDone !== 1'b0 || bus.jumpValid !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_regs drop=%0d initDone=%b jv=%b want 0/0/0", dropCount, initDone, bus.jumpValid);
                end
            end
            checks++;
            if (readyIn) begin
                if (bus.tableEn !== 1'b1 || bus.tableWe !== 1'b1 || bus.tableAddr !== 6'(initCnt) || bus.tableWdata !== 2'b10) begin
                    failures++;
                    $display("FAIL rst_init k=%0d en=%b we=%b addr=%0d data=%b want 1/1/%0d/10",
                             k, bus.tableEn, bus.tableWe, bus.tableAddr, bus.tableWdata, initCnt);
                end
                initCnt++;
            end else if (bus.tableEn !== 1'b0 || bus.predictReady !== 1'b0) begin
                failures++;
                $display("FAIL rst_frozen k=%0d en=%b ready=%b want 0/0", k, bus.tableEn, bus.predictReady);
            end
        end
        guard = 0;
        while (initCnt < 64 && guard < 100) begin
            step();
            readyIn = 1'b1;
            bus.updateFlag = 1'b0;
            @(negedge clockIn);
            if (bus.tableEn !== 1'b1 || bus.tableWe !== 1'b1 || bus.tableAddr !== 6'(initCnt)) begin
                checks++;
                failures++;
                $display("FAIL rst_init_tail en=%b we=%b addr=%0d want 1/1/%0d", bus.tableEn, bus.tableWe, bus.tableAddr, initCnt);
            end
            initCnt++;
            guard++;
        end
        step();
        @(negedge clockIn);
        checks++;
        if (initDone !== 1'b1 || dropCount !== 16'd3) begin
            failures++;
            $display("FAIL rst_drops initDone=%b drop=%0d want 1/3", initDone, dropCount);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            @(negedge clockIn);
            if (bus.tableEn === 1'b1 && bus.tableWe === 1'b1) begin
                checks++;
                if (expWr.size() == 0) begin
                    failures++;
                    $display("FAIL rst_drain extra write addr=%0d data=%b", bus.tableAddr, bus.tableWdata);
                end else begin
                    w = expWr.pop_front();
                    if (bus.tableAddr !== w.addr || bus.tableWdata !== w.data) begin
                        failures++;
                        $display("FAIL rst_drain addr=%0d data=%b want addr=%0d data=%b",
                                 bus.tableAddr, bus.tableWdata, w.addr, w.data);
                    end
                end
            end
        end
        checks++;
        if (expWr.size() != 0) begin
            failures++;
            $display("FAIL rst_drain_pending got=%0d want=0", expWr.size());
        end
    endtask

    initial begin
        bus.predictValid = 1'b0;
        bus.predictAddr  = 32'h0;
        bus.updateFlag   = 1'b0;
        bus.updateAddr   = 32'h0;
        bus.updateVal    = 1'b0;
        test_reset();
        test_init();
        test_lookup();
        test_update_rmw();
        test_starve();
        test_back_to_back();
        test_reset_in_rmw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
